// File: rtl/rgb_arb_pkg.sv
// ----------------------------------------------------------------------------
// rgb_arb_pkg
// Shared types and constants for the two-requester RGB converter arbiter:
//   - state_t          : arbiter FSM state encoding
//   - CONV_LATENCY_DEF : default converter latency in clock cycles
//   - COLOUR_W, RGB_W  : colour code and rgb result widths
//   - onehot_to_idx    : index of the set bit in a two-bit one-hot vector
// ----------------------------------------------------------------------------
package rgb_arb_pkg;

   localparam int unsigned CONV_LATENCY_DEF = 1;
   localparam int unsigned COLOUR_W         = 3;
   localparam int unsigned RGB_W            = 24;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // A zero vector maps to index 0; callers only use the result when a
   // request is present.
   function automatic logic onehot_to_idx(input logic [1:0] oh);
      return oh[1];
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// ----------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin selector (purely combinational).
// Ports:
//   req     in  [1:0]  active requests
//   pointer in  1      requester that wins when both request
//   winner  out [1:0]  one-hot winner, zero when no request
// ----------------------------------------------------------------------------
module rr_arbiter2
   import rgb_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       pointer,
   output logic [1:0] winner
);

   // Single requests win outright; a tie goes to the pointed-at requester
   always_comb begin
      winner = 2'b00;
      case (req)
         2'b00:   winner = 2'b00;
         2'b01:   winner = 2'b01;
         2'b10:   winner = 2'b10;
         2'b11:   winner = pointer ? 2'b10 : 2'b01;
         default: winner = 2'b00;
      endcase
   end

endmodule

// File: rtl/rgb_arbiter.sv
// ----------------------------------------------------------------------------
// rgb_arbiter
// Shares one RGB colour converter between two requesters. A request seen in
// IDLE is granted in ISSUE (one-cycle gnt pulse, converter enabled with the
// winner's colour), the converter latency elapses in WAIT, the result is
// captured on the last WAIT cycle and announced in DONE with rgb_valid.
// Ports:
//   clk          in   clock, all state changes on the rising edge
//   rst_n        in   synchronous active-low reset
//   req          in   [1:0] requests, held until granted
//   colour0/1    in   [2:0] colour code of each requester
//   gnt          out  [1:0] one-hot, one-cycle grant pulse
//   conv_enable  out  converter enable (high in ISSUE only)
//   conv_colour  out  [2:0] colour code to the converter, held outside ISSUE
//   conv_rgb     in   [23:0] converter result
//   rgb_out      out  [23:0] captured result, held until the next capture
//   rgb_valid    out  one-cycle pulse when rgb_out updates
//   rgb_id       out  requester owning rgb_out
// ----------------------------------------------------------------------------
module rgb_arbiter
   import rgb_arb_pkg::*;
#(
   parameter int unsigned CONV_LATENCY = CONV_LATENCY_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [1:0]          req,
   input  logic [COLOUR_W-1:0] colour0,
   input  logic [COLOUR_W-1:0] colour1,
   output logic [1:0]          gnt,
   output logic                conv_enable,
   output logic [COLOUR_W-1:0] conv_colour,
   input  logic [RGB_W-1:0]    conv_rgb,
   output logic [RGB_W-1:0]    rgb_out,
   output logic                rgb_valid,
   output logic                rgb_id
);

   // WAIT runs while the counter steps from CONV_LATENCY-1 down to 0.
   localparam logic [2:0] WAIT_LOAD = 3'(CONV_LATENCY - 1);

   state_t              state;
   logic [2:0]          wait_cnt;
   logic                prio;        // requester that wins the next tie
   logic                owner;       // requester of the transaction in flight
   logic [1:0]          win_oh;
   logic                win_idx;
   logic [COLOUR_W-1:0] win_colour;

   rr_arbiter2 u_rr (
      .req     (req),
      .pointer (prio),
      .winner  (win_oh)
   );

   // Winner index and the colour code it presents
   always_comb begin
      win_idx = onehot_to_idx(win_oh);
      if (win_idx) begin
         win_colour = colour1;
      end else begin
         win_colour = colour0;
      end
   end

   // Arbiter FSM; outputs are registered so they line up with the state
   // they belong to (gnt/conv_enable in ISSUE, rgb_valid in DONE).
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         wait_cnt    <= 3'd0;
         prio        <= 1'b0;
         owner       <= 1'b0;
         gnt         <= 2'b00;
         conv_enable <= 1'b0;
         conv_colour <= '0;
         rgb_out     <= '0;
         rgb_valid   <= 1'b0;
         rgb_id      <= 1'b0;
      end else begin
         gnt         <= 2'b00;
         conv_enable <= 1'b0;
         rgb_valid   <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req != 2'b00) begin
                  state       <= ST_ISSUE;
                  owner       <= win_idx;
                  gnt         <= win_oh;
                  conv_enable <= 1'b1;
                  conv_colour <= win_colour;
                  // The requester just granted drops to lowest priority.
                  prio        <= ~win_idx;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_ISSUE: begin
               wait_cnt <= WAIT_LOAD;
               state    <= ST_WAIT;
            end
            ST_WAIT: begin
               if (wait_cnt == 3'd0) begin
                  rgb_out   <= conv_rgb;
                  rgb_id    <= owner;
                  rgb_valid <= 1'b1;
                  state     <= ST_DONE;
               end else begin
                  wait_cnt <= wait_cnt - 3'd1;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rgb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_rgb_arbiter
// Bench for rgb_arbiter with CONV_LATENCY=1 and a one-cycle registered RGB
// colour converter. A transaction-timeline model predicts every output on
// every cycle; directed scenarios pin the model with literal expectations,
// followed by randomized request traffic with occasional resets.
// ----------------------------------------------------------------------------
module tb_rgb_arbiter;

   localparam int L = 1;

   logic        clk;
   logic        rst_n;
   logic [1:0]  req;
   logic [2:0]  colour0;
   logic [2:0]  colour1;
   logic [1:0]  gnt;
   logic        conv_enable;
   logic [2:0]  conv_colour;
   logic [23:0] conv_rgb;
   logic [23:0] rgb_out;
   logic        rgb_valid;
   logic        rgb_id;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   rgb_arbiter #(.CONV_LATENCY(L)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .colour0     (colour0),
      .colour1     (colour1),
      .gnt         (gnt),
      .conv_enable (conv_enable),
      .conv_colour (conv_colour),
      .conv_rgb    (conv_rgb),
      .rgb_out     (rgb_out),
      .rgb_valid   (rgb_valid),
      .rgb_id      (rgb_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Colour code bit 2/1/0 switches the red/green/blue byte fully on.
   function automatic logic [23:0] expand(input logic [2:0] c);
      return {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
   endfunction

   // RGB colour converter, one cycle from enabled sample to result
   always @(posedge clk) begin
      if (!rst_n) conv_rgb <= 24'h000000;
      else if (conv_enable) conv_rgb <= expand(conv_colour);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural model + per-cycle compare ----------------
   // Timeline view: a request seen at the end of an idle cycle t is granted
   // in cycle t+1, its result appears in cycle t+L+2 and the arbiter is idle
   // again from cycle t+L+3.
   bit          m_ready   = 0;
   int          m_idle_at = 0;
   int          m_valid_at = -1;
   int          m_prio    = 0;
   logic [1:0]  m_gnt;
   logic        m_en;
   logic [2:0]  m_colour;
   logic [23:0] m_rgb;
   logic        m_id;
   logic        m_valid;
   logic [23:0] m_pend_rgb;
   logic        m_pend_id;

   initial begin
      int w;
      forever begin
         @(posedge clk);
         cyc++;
         if (!rst_n) begin
            m_ready    = 1;
            m_idle_at  = cyc;
            m_valid_at = -1;
            m_prio     = 0;
            m_gnt      = 2'b00;
            m_en       = 1'b0;
            m_colour   = 3'b000;
            m_rgb      = 24'h000000;
            m_id       = 1'b0;
            m_valid    = 1'b0;
         end else begin
            m_gnt   = 2'b00;
            m_en    = 1'b0;
            m_valid = 1'b0;
            if (cyc == m_valid_at) begin
               m_rgb   = m_pend_rgb;
               m_id    = m_pend_id;
               m_valid = 1'b1;
            end
            if ((cyc - 1) >= m_idle_at && req != 2'b00) begin
               if (req == 2'b11) w = m_prio;
               else w = req[1] ? 1 : 0;
               m_gnt      = (w == 1) ? 2'b10 : 2'b01;
               m_en       = 1'b1;
               m_colour   = (w == 1) ? colour1 : colour0;
               m_pend_rgb = expand(m_colour);
               m_pend_id  = (w == 1);
               m_valid_at = cyc + L + 1;
               m_idle_at  = cyc + L + 2;
               m_prio     = 1 - w;
            end
         end
         @(negedge clk);
         if (m_ready) begin
            chk("gnt",         32'(gnt),         32'(m_gnt));
            chk("conv_enable", 32'(conv_enable), 32'(m_en));
            chk("conv_colour", 32'(conv_colour), 32'(m_colour));
            chk("rgb_valid",   32'(rgb_valid),   32'(m_valid));
            chk("rgb_out",     32'(rgb_out),     32'(m_rgb));
            chk("rgb_id",      32'(rgb_id),      32'(m_id));
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req   = 2'b00;
      rst_n = 1'b0;
      tick();
      tick();
      chk("rst_gnt",         32'(gnt),         32'h0);
      chk("rst_conv_enable", 32'(conv_enable), 32'h0);
      chk("rst_conv_colour", 32'(conv_colour), 32'h0);
      chk("rst_rgb_out",     32'(rgb_out),     32'h0);
      chk("rst_rgb_valid",   32'(rgb_valid),   32'h0);
      chk("rst_rgb_id",      32'(rgb_id),      32'h0);
      rst_n = 1'b1;
   endtask

   task automatic wait_gnt(input bit drop, output int g_idx, output int g_cyc);
      bit got = 0;
      g_idx = -1;
      g_cyc = -1;
      for (int i = 0; i < 20 && !got; i++) begin
         tick();
         if (gnt != 2'b00) begin
            got   = 1;
            g_cyc = cyc;
            g_idx = gnt[1] ? 1 : 0;
            if (drop) req = req & ~gnt;
         end
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL gnt_timeout: no grant within 20 cycles, expected one");
      end
   endtask

   task automatic wait_valid(output int v_cyc, output logic [23:0] v_rgb, output logic v_id);
      bit got = 0;
      v_cyc = -1;
      v_rgb = 24'h000000;
      v_id  = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         tick();
         if (rgb_valid) begin
            got   = 1;
            v_cyc = cyc;
            v_rgb = rgb_out;
            v_id  = rgb_id;
         end
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL valid_timeout: no rgb_valid within 20 cycles, expected one");
      end
   endtask

   // ---------------- directed + random stimulus ----------------
   initial begin
      int          start, g_idx, g_cyc, g2_idx, g2_cyc, v_cyc, v2_cyc;
      logic [23:0] v_rgb, v2_rgb;
      logic        v_id, v2_id;

      rst_n   = 1'b0;
      req     = 2'b00;
      colour0 = 3'b000;
      colour1 = 3'b000;

      // Reset
      do_reset();

      // Single request from requester 0
      req = 2'b01; colour0 = 3'b100; start = cyc;
      wait_gnt(1, g_idx, g_cyc);
      chk("single_gnt_idx", 32'(g_idx), 32'd0);
      chk("single_gnt_cyc", 32'(g_cyc - start), 32'd1);
      wait_valid(v_cyc, v_rgb, v_id);
      chk("single_valid_cyc", 32'(v_cyc - start), 32'd3);
      chk("single_rgb", 32'(v_rgb), 32'h00FF0000);
      chk("single_id",  32'(v_id),  32'd0);
      repeat (2) tick();

      // Simultaneous requests after reset: 0 first, then 1, 4 cycles apart
      do_reset();
      req = 2'b11; colour0 = 3'b001; colour1 = 3'b010;
      wait_gnt(1, g_idx, g_cyc);
      wait_valid(v_cyc, v_rgb, v_id);
      wait_gnt(1, g2_idx, g2_cyc);
      wait_valid(v2_cyc, v2_rgb, v2_id);
      chk("sim_first_idx",  32'(g_idx),  32'd0);
      chk("sim_first_rgb",  32'(v_rgb),  32'h000000FF);
      chk("sim_second_idx", 32'(g2_idx), 32'd1);
      chk("sim_second_rgb", 32'(v2_rgb), 32'h0000FF00);
      chk("sim_second_id",  32'(v2_id),  32'd1);
      chk("sim_gnt_gap",    32'(g2_cyc - g_cyc), 32'd4);
      chk("sim_valid_gap",  32'(v2_cyc - v_cyc), 32'd4);
      repeat (2) tick();

      // Fairness: both held for 8 services
      do_reset();
      req = 2'b11; colour0 = 3'b011; colour1 = 3'b110;
      for (int k = 0; k < 8; k++) begin
         wait_gnt(0, g_idx, g_cyc);
         chk("fair_order", 32'(g_idx), 32'(k % 2));
         wait_valid(v_cyc, v_rgb, v_id);
         chk("fair_valid_id", 32'(v_id), 32'(k % 2));
         chk("fair_valid_cyc", 32'(v_cyc - g_cyc), 32'd2);
      end
      req = 2'b00;
      repeat (3) tick();

      // Reset during WAIT aborts the transaction
      req = 2'b01; colour0 = 3'b111;
      wait_gnt(1, g_idx, g_cyc);
      tick();
      rst_n = 1'b0;
      for (int k = 0; k < 2; k++) begin
         tick();
         chk("abort_no_valid", 32'(rgb_valid), 32'h0);
         chk("abort_rgb_out",  32'(rgb_out),   32'h0);
      end
      rst_n = 1'b1;
      tick();
      chk("abort_no_valid_after", 32'(rgb_valid), 32'h0);
      req = 2'b10; colour1 = 3'b011;
      wait_gnt(1, g_idx, g_cyc);
      chk("abort_next_idx", 32'(g_idx), 32'd1);
      wait_valid(v_cyc, v_rgb, v_id);
      chk("abort_next_rgb", 32'(v_rgb), 32'h0000FFFF);
      chk("abort_next_id",  32'(v_id),  32'd1);
      repeat (2) tick();

      // Late request raised during requester 0's WAIT
      req = 2'b01; colour0 = 3'b110;
      wait_gnt(1, g_idx, g_cyc);
      tick();
      req[1] = 1'b1; colour1 = 3'b101;
      wait_gnt(1, g2_idx, g2_cyc);
      chk("late_idx", 32'(g2_idx), 32'd1);
      chk("late_gap", 32'(g2_cyc - g_cyc), 32'd4);
      wait_valid(v_cyc, v_rgb, v_id);
      chk("late_rgb", 32'(v_rgb), 32'h00FF00FF);
      repeat (2) tick();

      // Randomized traffic with occasional resets
      for (int n = 0; n < 1500; n++) begin
         tick();
         if (rst_n == 1'b0) rst_n = 1'b1;
         else if ($urandom_range(0, 149) == 0) rst_n = 1'b0;
         for (int b = 0; b < 2; b++) begin
            if (req[b]) begin
               if (gnt[b] && $urandom_range(0, 9) < 8) req[b] = 1'b0;
               else if ($urandom_range(0, 19) == 0) req[b] = 1'b0;
            end else if ($urandom_range(0, 9) < 3) begin
               req[b] = 1'b1;
               if (b == 0) colour0 = 3'($urandom_range(0, 7));
               else        colour1 = 3'($urandom_range(0, 7));
            end
         end
      end
      req = 2'b00;
      repeat (6) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rgb_arbiter.md
RGB_ARBITER -- requirements
Module: rgb_arbiter

Interface
REQ-001 Parameter CONV_LATENCY, default 1, SHALL be the converter's clock cycles from enabled colour sample to valid rgb (legal range 1..7).
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the synchronous active-low reset, sampled on the rising edge of clk.
REQ-004 req  input  2  SHALL carry per-requester conversion requests, held high until granted.
REQ-005 colour0  input  3  SHALL be requester 0's 3-bit colour code, stable while req[0] is high.
REQ-006 colour1  input  3  SHALL be requester 1's 3-bit colour code, stable while req[1] is high.
REQ-007 gnt  output  2  SHALL be a one-hot, one-cycle grant pulse.
REQ-008 conv_enable  output  1  SHALL be the enable to the shared RGB colour converter.
REQ-009 conv_colour  output  3  SHALL be the colour code driven to the converter.
REQ-010 conv_rgb  input  24  SHALL be the converter's rgb result.
REQ-011 rgb_out  output  24  SHALL be the captured result, held until the next capture.
REQ-012 rgb_valid  output  1  SHALL pulse high for one cycle when rgb_out updates.
REQ-013 rgb_id  output  1  SHALL be the index of the requester owning rgb_out.

Function
REQ-014 FSM states SHALL be IDLE, ISSUE, WAIT and DONE.
REQ-015 IDLE SHALL go to ISSUE when req != 0; otherwise it SHALL stay in IDLE.
REQ-016 The winner SHALL be chosen in IDLE by two-way round-robin; the last-granted requester has lowest priority.
REQ-017 In ISSUE: conv_enable=1, conv_colour = winner's colour, gnt[winner]=1 for exactly this cycle; next state WAIT.
REQ-018 WAIT SHALL last exactly CONV_LATENCY cycles, counted by a 3-bit down-counter loaded in ISSUE.
REQ-019 On the last WAIT cycle, conv_rgb SHALL be registered into rgb_out and the winner into rgb_id; next state DONE.
REQ-020 In DONE: rgb_valid=1 for one cycle; next state IDLE.
REQ-021 Timing: req seen in IDLE at cycle 0 -> gnt at cycle 1 -> rgb_valid at cycle CONV_LATENCY+2; back-to-back service period = CONV_LATENCY+3 cycles.
REQ-022 conv_enable SHALL be 0 in IDLE, WAIT and DONE; conv_colour SHALL hold its last value outside ISSUE.
REQ-023 Requests arriving outside IDLE SHALL be ignored until the next IDLE; requests dropped before grant SHALL NOT be serviced.
REQ-024 If both req bits are high continuously, grants SHALL strictly alternate 0,1,0,1...
REQ-025 rgb_out and rgb_id SHALL change only on the REQ-019 capture.

Reset
REQ-026 rst_n=0 at a rising edge SHALL force IDLE, zero the WAIT counter and set the priority pointer so requester 0 wins the first tie.
REQ-027 Reset values SHALL be: gnt=0, conv_enable=0, conv_colour=0, rgb_out=0, rgb_valid=0, rgb_id=0.
REQ-028 Reset asserted mid-transaction (ISSUE/WAIT/DONE) SHALL abort it without rgb_valid and without updating rgb_out.

Structure
REQ-029 Package rgb_arb_pkg SHALL hold the state enum, the CONV_LATENCY default and the colour/rgb width constants (3, 24).
REQ-030 Round-robin selection SHALL be a sub-module rr_arbiter2 (inputs req, pointer; output one-hot winner).

Verification
REQ-031 The bench SHALL connect conv_* to the team's RGB colour converter with CONV_LATENCY=1.
REQ-032 Reset: after rst_n=0 for 2 cycles -> all outputs 0 and state IDLE.
REQ-033 Single request: req=2'b01, colour0=3'b100 -> gnt=2'b01 at cycle 1, rgb_valid at cycle 3, rgb_out=24'hFF0000, rgb_id=0.
REQ-034 Simultaneous request after reset: req=2'b11, colour0=3'b001, colour1=3'b010 -> requester 0 first (24'h0000FF), then requester 1 (24'h00FF00), 4 cycles apart.
REQ-035 Fairness: req=2'b11 held for 8 services -> gnt order 0,1,0,1,0,1,0,1; one rgb_valid per grant.
REQ-036 Reset mid-WAIT: rst_n=0 during WAIT -> no rgb_valid; rgb_out=0; next req=2'b10 served normally.
REQ-037 Late request: req[1] raised during WAIT of requester 0 -> requester 1 granted in the ISSUE following the next IDLE, never in the same transaction.
